// File: rtl/memory_map.sv
// memory_map: responder for the CPU data-memory bus. Decodes the 12-bit
// nibble address onto general RAM, display RAM (with a second LCD read
// port) and the timer / interrupt I/O registers. Read data, LCD data and
// the interrupt request are all registered.
module memory_map #(
    parameter int RAM_NIBBLES  = 640,
    parameter int VRAM_NIBBLES = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memory_write_en,
    input  logic        memory_read_en,
    input  logic [11:0] memory_addr,
    input  logic [3:0]  memory_write_data,
    output logic [3:0]  memory_read_data,
    input  logic        timer_tick,
    input  logic [6:0]  lcd_addr,
    output logic [3:0]  lcd_data,
    output logic        irq
);

    localparam int          RAM_AW     = $clog2(RAM_NIBBLES);
    localparam int          VRAM_AW    = $clog2(VRAM_NIBBLES);
    localparam logic [11:0] RAM_END    = 12'(RAM_NIBBLES);
    localparam logic [11:0] VRAM_BASE  = 12'hE00;
    localparam logic [11:0] VRAM_SIZE  = 12'(VRAM_NIBBLES);
    localparam logic [11:0] ADDR_FLAGS = 12'hF00;
    localparam logic [11:0] ADDR_MASK  = 12'hF10;
    localparam logic [11:0] ADDR_TMR_L = 12'hF20;
    localparam logic [11:0] ADDR_TMR_H = 12'hF21;
    localparam logic [11:0] ADDR_CTRL  = 12'hF76;

    logic [3:0] ram_mem  [RAM_NIBBLES];
    logic [3:0] vram_mem [VRAM_NIBBLES];

    logic [3:0] read_data_q, read_data_d;
    logic [3:0] lcd_data_q,  lcd_data_d;
    logic [3:0] flags_q,     flags_d;
    logic [3:0] mask_q,      mask_d;
    logic [7:0] timer_q,     timer_d;
    logic       irq_q,       irq_d;

    logic               wr_s;
    logic               rd_s;
    logic               ram_hit_s;
    logic               vram_hit_s;
    logic [11:0]        vram_off_s;
    logic [RAM_AW-1:0]  ram_idx_s;
    logic [VRAM_AW-1:0] vram_idx_s;
    logic               lcd_hit_s;
    logic               tmrst_s;
    logic [7:0]         timer_inc_s;
    logic [3:0]         fall_s;
    logic [3:0]         rd_val_s;

    // Address decode; a write strobe suppresses any coincident read.
    always_comb begin
        wr_s       = memory_write_en;
        rd_s       = memory_read_en & ~memory_write_en;
        ram_hit_s  = (memory_addr < RAM_END);
        vram_off_s = memory_addr - VRAM_BASE;
        vram_hit_s = (memory_addr >= VRAM_BASE) && (vram_off_s < VRAM_SIZE);
        ram_idx_s  = memory_addr[RAM_AW-1:0];
        vram_idx_s = vram_off_s[VRAM_AW-1:0];
        lcd_hit_s  = ({5'd0, lcd_addr} < VRAM_SIZE);
    end

    // Read multiplexer over RAM, VRAM and the I/O registers (pre-update values).
    always_comb begin
        rd_val_s = 4'h0;
        if (ram_hit_s) begin
            rd_val_s = ram_mem[ram_idx_s];
        end else if (vram_hit_s) begin
            rd_val_s = vram_mem[vram_idx_s];
        end else begin
            case (memory_addr)
                ADDR_FLAGS: rd_val_s = flags_q;
                ADDR_MASK:  rd_val_s = mask_q;
                ADDR_TMR_L: rd_val_s = timer_q[3:0];
                ADDR_TMR_H: rd_val_s = timer_q[7:4];
                default:    rd_val_s = 4'h0;
            endcase
        end
    end

    // Timer, interrupt flags, mask, irq and read-port next state.
    always_comb begin
        read_data_d = read_data_q;
        timer_d     = timer_q;
        fall_s      = 4'h0;
        tmrst_s     = wr_s && (memory_addr == ADDR_CTRL) && memory_write_data[0];
        timer_inc_s = timer_q + 8'd1;

        if (rd_s) begin
            read_data_d = rd_val_s;
        end else begin
            read_data_d = read_data_q;
        end

        // The clear has priority over a tick and never raises a flag itself.
        if (tmrst_s) begin
            timer_d = 8'h00;
            fall_s  = 4'h0;
        end else if (timer_tick) begin
            timer_d = timer_inc_s;
            fall_s  = {timer_q[7] & ~timer_inc_s[7],
                       timer_q[6] & ~timer_inc_s[6],
                       timer_q[4] & ~timer_inc_s[4],
                       timer_q[2] & ~timer_inc_s[2]};
        end else begin
            timer_d = timer_q;
            fall_s  = 4'h0;
        end

        // Clear-on-read first, then OR in new events so a same-cycle set survives.
        if (rd_s && (memory_addr == ADDR_FLAGS)) begin
            flags_d = fall_s;
        end else begin
            flags_d = flags_q | fall_s;
        end

        if (wr_s && (memory_addr == ADDR_MASK)) begin
            mask_d = memory_write_data;
        end else begin
            mask_d = mask_q;
        end

        irq_d = |(flags_q & mask_q);

        if (lcd_hit_s) begin
            lcd_data_d = vram_mem[lcd_addr[VRAM_AW-1:0]];
        end else begin
            lcd_data_d = 4'h0;
        end
    end

    // Register bank with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            read_data_q <= 4'h0;
            lcd_data_q  <= 4'h0;
            flags_q     <= 4'h0;
            mask_q      <= 4'h0;
            timer_q     <= 8'h00;
            irq_q       <= 1'b0;
        end else begin
            read_data_q <= read_data_d;
            lcd_data_q  <= lcd_data_d;
            flags_q     <= flags_d;
            mask_q      <= mask_d;
            timer_q     <= timer_d;
            irq_q       <= irq_d;
        end
    end

    // Memory array writes; contents survive reset but a write during reset is dropped.
    always_ff @(posedge clk) begin
        if (reset_n && wr_s && ram_hit_s) begin
            ram_mem[ram_idx_s] <= memory_write_data;
        end
        if (reset_n && wr_s && vram_hit_s) begin
            vram_mem[vram_idx_s] <= memory_write_data;
        end
    end

    assign memory_read_data = read_data_q;
    assign lcd_data         = lcd_data_q;
    assign irq              = irq_q;

endmodule

// File: tb/tb_memory_map.sv
// Directed scoreboard bench for memory_map: expected values are queued
// when stimulus is driven and popped when the registered output is sampled.
module tb_memory_map;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        memory_write_en;
    logic        memory_read_en;
    logic [11:0] memory_addr;
    logic [3:0]  memory_write_data;
    logic [3:0]  memory_read_data;
    logic        timer_tick;
    logic [6:0]  lcd_addr;
    logic [3:0]  lcd_data;
    logic        irq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];

    memory_map dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .memory_write_en   (memory_write_en),
        .memory_read_en    (memory_read_en),
        .memory_addr       (memory_addr),
        .memory_write_data (memory_write_data),
        .memory_read_data  (memory_read_data),
        .timer_tick        (timer_tick),
        .lcd_addr          (lcd_addr),
        .lcd_data          (lcd_data),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    task automatic push(input string t, input logic [3:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [3:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit after posedge.
    task automatic drive(input logic we, input logic re, input logic [11:0] a,
                         input logic [3:0] d, input logic tk);
        @(negedge clk);
        memory_write_en   = we;
        memory_read_en    = re;
        memory_addr       = a;
        memory_write_data = d;
        timer_tick        = tk;
        @(posedge clk);
        #1;
        memory_write_en = 1'b0;
        memory_read_en  = 1'b0;
        timer_tick      = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [3:0] d);
        drive(1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic rd(input string t, input logic [11:0] a, input logic [3:0] exp);
        push(t, exp);
        drive(1'b0, 1'b1, a, 4'h0, 1'b0);
        pop_check(memory_read_data);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 12'h000, 4'h0, 1'b1);
        end
    endtask

    task automatic check_irq(input string t, input logic exp);
        push(t, {3'b000, exp});
        pop_check({3'b000, irq});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n           = 1'b0;
        memory_write_en   = 1'b0;
        memory_read_en    = 1'b0;
        memory_addr       = 12'h000;
        memory_write_data = 4'h0;
        timer_tick        = 1'b0;
        lcd_addr          = 7'h00;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        push("reset_read_data", 4'h0);
        pop_check(memory_read_data);
        push("reset_lcd_data", 4'h0);
        pop_check(lcd_data);
        check_irq("reset_irq", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // RAM read/write, boundary, hold, write-wins, unmapped
        wr(12'h123, 4'hA);
        rd("ram_123", 12'h123, 4'hA);
        wr(12'h010, 4'h3);
        wr(12'h27F, 4'h7);
        rd("ram_last", 12'h27F, 4'h7);
        push("read_hold_no_strobe", 4'h7);
        drive(1'b0, 1'b0, 12'h123, 4'h0, 1'b0);
        pop_check(memory_read_data);
        push("write_wins_hold", 4'h7);
        drive(1'b1, 1'b1, 12'h123, 4'h6, 1'b0);
        pop_check(memory_read_data);
        rd("ram_after_write_wins", 12'h123, 4'h6);
        wr(12'h280, 4'h5);
        rd("ram_past_end", 12'h280, 4'h0);
        wr(12'h500, 4'hF);
        rd("unmapped", 12'h500, 4'h0);

        // VRAM and LCD port
        wr(12'hE05, 4'h5);
        lcd_addr = 7'h05;
        push("lcd_05", 4'h5);
        drive(1'b0, 1'b0, 12'h000, 4'h0, 1'b0);
        pop_check(lcd_data);
        wr(12'hE7F, 4'hB);
        lcd_addr = 7'h7F;
        push("lcd_7f", 4'hB);
        drive(1'b0, 1'b0, 12'h000, 4'h0, 1'b0);
        pop_check(lcd_data);
        rd("cpu_vram_7f", 12'hE7F, 4'hB);
        lcd_addr = 7'h05;
        push("lcd_same_cycle_old", 4'h5);
        drive(1'b1, 1'b0, 12'hE05, 4'h8, 1'b0);
        pop_check(lcd_data);
        push("lcd_after_write", 4'h8);
        drive(1'b0, 1'b0, 12'h000, 4'h0, 1'b0);
        pop_check(lcd_data);

        // Timer, IT32 flag, mask and irq
        ticks(8);
        check_irq("irq_unmasked", 1'b0);
        wr(12'hF10, 4'h1);
        check_irq("irq_lag", 1'b0);
        drive(1'b0, 1'b0, 12'h000, 4'h0, 1'b0);
        check_irq("irq_set", 1'b1);
        rd("mask_rd", 12'hF10, 4'h1);
        rd("timer_lo_8", 12'hF20, 4'h8);
        rd("timer_hi_8", 12'hF21, 4'h0);
        rd("flags_it32", 12'hF00, 4'h1);
        rd("flags_cleared", 12'hF00, 4'h0);
        check_irq("irq_cleared", 1'b0);

        // Full wrap from reset; RAM retains contents
        do_reset();
        check_irq("irq_after_reset", 1'b0);
        rd("ram_survives_reset", 12'h123, 4'h6);
        ticks(32);
        rd("flags_32", 12'hF00, 4'h3);
        ticks(224);
        rd("flags_wrap", 12'hF00, 4'hF);
        rd("timer_lo_wrap", 12'hF20, 4'h0);
        rd("timer_hi_wrap", 12'hF21, 4'h0);

        // Set beats clear-on-read
        ticks(7);
        push("rd_with_tick_old", 4'h0);
        drive(1'b0, 1'b1, 12'hF00, 4'h0, 1'b1);
        pop_check(memory_read_data);
        rd("it32_survived", 12'hF00, 4'h1);
        rd("it32_cleared", 12'hF00, 4'h0);

        // Timer clear via control register
        ticks(47);
        rd("flags_to_37", 12'hF00, 4'h3);
        rd("timer_lo_37", 12'hF20, 4'h7);
        rd("timer_hi_37", 12'hF21, 4'h3);
        wr(12'hF76, 4'h2);
        rd("ctrl_bit0_zero", 12'hF20, 4'h7);
        drive(1'b1, 1'b0, 12'hF76, 4'h1, 1'b1);
        rd("tmrst_lo", 12'hF20, 4'h0);
        rd("tmrst_hi", 12'hF21, 4'h0);
        rd("tmrst_no_flags", 12'hF00, 4'h0);

        // Mid-operation reset aborts a write and zeroes registers
        wr(12'hF10, 4'hF);
        ticks(8);
        drive(1'b0, 1'b0, 12'h000, 4'h0, 1'b0);
        check_irq("irq_before_reset", 1'b1);
        rd("ram_before_reset", 12'h123, 4'h6);
        @(negedge clk);
        reset_n           = 1'b0;
        memory_write_en   = 1'b1;
        memory_addr       = 12'h010;
        memory_write_data = 4'hC;
        @(posedge clk);
        #1;
        memory_write_en = 1'b0;
        push("midreset_read_data", 4'h0);
        pop_check(memory_read_data);
        push("midreset_lcd_data", 4'h0);
        pop_check(lcd_data);
        check_irq("midreset_irq", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        rd("midreset_mask", 12'hF10, 4'h0);
        rd("midreset_flags", 12'hF00, 4'h0);
        rd("midreset_timer", 12'hF20, 4'h0);
        rd("write_aborted", 12'h010, 4'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
